// File: rtl/argmax_ctrl.sv
// rtl/argmax_ctrl.sv - sequencer between the fp16 dot-product engine and the running-max comparator
module argmax_ctrl #(
  parameter int NUM_C = 10,
  parameter int LBL_W = $clog2(NUM_C)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_score,
  input  logic             s_last,
  output logic             max_clear,
  output logic             max_en,
  output logic [15:0]      max_a,
  output logic [LBL_W-1:0] max_label,
  input  logic [LBL_W-1:0] max_label_o,
  input  logic [15:0]      max_value,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [LBL_W-1:0] m_label,
  output logic [15:0]      m_score,
  output logic             m_err
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [LBL_W-1:0] CNT_TOP = LBL_W'(NUM_C - 1);

  state_t           state, state_nx;
  logic [LBL_W-1:0] cnt, cnt_nx;
  logic             err, err_nx;

  // The comparator sees every score; only max_en decides whether it counts.
  assign max_a     = s_score;
  assign max_label = cnt;

  // State, class counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
    end
  end

  // Next-state and handshake decode; a beat at the top class always closes the inference.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    err_nx    = err;
    s_ready   = 1'b0;
    max_clear = 1'b0;
    max_en    = 1'b0;
    m_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) state_nx = CLEAR;
      end
      CLEAR: begin
        max_clear = 1'b1;
        cnt_nx    = '0;
        err_nx    = 1'b0;
        state_nx  = ACCUM;
      end
      ACCUM: begin
        s_ready = 1'b1;
        max_en  = s_valid;
        if (s_valid) begin
          // s_last must coincide exactly with the top class; any mismatch is a count error.
          err_nx = err | (s_last ^ (cnt == CNT_TOP));
          if ((cnt == CNT_TOP) || s_last) state_nx = DRAIN;
          else                            cnt_nx   = cnt + LBL_W'(1);
        end
      end
      DRAIN: begin
        state_nx = CAPTURE;
      end
      CAPTURE: begin
        state_nx = DONE;
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Result registers load only in CAPTURE and otherwise hold their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_label <= '0;
      m_score <= 16'h0000;
      m_err   <= 1'b0;
    end else if (state == CAPTURE) begin
      m_label <= max_label_o;
      m_score <= max_value;
      m_err   <= err;
    end
  end

endmodule

// File: tb/tb_argmax_ctrl.sv
// tb/tb_argmax_ctrl.sv - directed self-checking bench for argmax_ctrl with a 2-stage comparator model
module tb_argmax_ctrl;

  localparam int NUM_C = 4;
  localparam int LBL_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [15:0]      s_score;
  logic             s_last;
  logic             max_clear;
  logic             max_en;
  logic [15:0]      max_a;
  logic [LBL_W-1:0] max_label;
  logic [LBL_W-1:0] max_label_o;
  logic [15:0]      max_value;
  logic             m_valid;
  logic             m_ready;
  logic [LBL_W-1:0] m_label;
  logic [15:0]      m_score;
  logic             m_err;

  int n_checks = 0;
  int n_errors = 0;
  int clr_cnt  = 0;

  always #5 clk = ~clk;

  argmax_ctrl #(.NUM_C(NUM_C)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_score(s_score), .s_last(s_last),
    .max_clear(max_clear), .max_en(max_en), .max_a(max_a), .max_label(max_label),
    .max_label_o(max_label_o), .max_value(max_value),
    .m_valid(m_valid), .m_ready(m_ready), .m_label(m_label), .m_score(m_score), .m_err(m_err)
  );

  // Comparator model: stage 1 registers the inputs, stage 2 keeps the strict running max.
  logic             p_en, p_clr, have;
  logic [15:0]      p_a, cmp_max;
  logic [LBL_W-1:0] p_lbl, cmp_lbl;

  function automatic logic [15:0] fp_key(input logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      p_en <= 1'b0; p_clr <= 1'b0; p_a <= '0; p_lbl <= '0;
      have <= 1'b0; cmp_max <= '0; cmp_lbl <= '0;
    end else begin
      p_en <= max_en; p_clr <= max_clear; p_a <= max_a; p_lbl <= max_label;
      if (p_clr) begin
        have <= 1'b0;
      end else if (p_en && (!have || fp_key(p_a) > fp_key(cmp_max))) begin
        have <= 1'b1; cmp_max <= p_a; cmp_lbl <= p_lbl;
      end
    end
  end
  assign max_value   = cmp_max;
  assign max_label_o = cmp_lbl;

  always @(posedge clk) if (max_clear) clr_cnt <= clr_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sends n beats (beat i = sc[16*i +: 16]), s_last on beat last_idx (-1 = never), then checks latency.
  task automatic infer(input logic [63:0] sc, input int n, input int last_idx);
    int clr0;
    int w;
    clr0 = clr_cnt;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_score = sc[16*i +: 16];
      s_last  = (i == last_idx);
      w = 0;
      while (!s_ready && w < 20) begin
        @(posedge clk); #1; w++;
      end
      if (!s_ready) begin
        check("s_ready_timeout", 32'(s_ready), 32'd1);
      end else begin
        check("max_en_beat", 32'(max_en), 32'd1);
        check("max_label_beat", 32'(max_label), 32'(i));
        check("max_a_beat", 32'(max_a), 32'(sc[16*i +: 16]));
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("lat_k1", 32'(m_valid), 32'd0);
    check("drain_en", 32'(max_en), 32'd0);
    @(posedge clk); #1;
    check("lat_k2", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_k3", 32'(m_valid), 32'd1);
    check("clear_pulses", 32'(clr_cnt - clr0), 32'd1);
  endtask

  task automatic take();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("m_valid_after_take", 32'(m_valid), 32'd0);
  endtask

  task automatic expect_result(input logic [1:0] lbl, input logic [15:0] sc, input logic e);
    check("m_label", 32'(m_label), 32'(lbl));
    check("m_score", 32'(m_score), 32'(sc));
    check("m_err", 32'(m_err), 32'(e));
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_score = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_max_clear", 32'(max_clear), 32'd0);
    check("rst_max_en", 32'(max_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_label", 32'(m_label), 32'd0);
    check("rst_m_score", 32'(m_score), 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic: 1.0, 2.0, -2.0, 0.5 -> class 1 wins.
    infer({16'h3800, 16'hC000, 16'h4000, 16'h3C00}, 4, 3);
    expect_result(2'd1, 16'h4000, 1'b0);
    take();
    check("label_hold_idle", 32'(m_label), 32'd1);

    // Tie at the top keeps the lowest label.
    infer({16'h3C00, 16'h3C00, 16'h4200, 16'h4200}, 4, 3);
    expect_result(2'd0, 16'h4200, 1'b0);
    take();

    // Early s_last on beat 2.
    infer({32'h0, 16'h4400, 16'h3C00}, 2, 1);
    expect_result(2'd1, 16'h4400, 1'b1);
    take();

    // Four beats without s_last: ends at the top class with an error; hold under back-pressure.
    infer({16'h4400, 16'h4000, 16'h3C00, 16'h3800}, 4, -1);
    expect_result(2'd3, 16'h4400, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_m_valid", 32'(m_valid), 32'd1);
      check("hold_s_ready", 32'(s_ready), 32'd0);
      expect_result(2'd3, 16'h4400, 1'b1);
    end
    take();

    // Back-to-back: stale max from the all-negative run must not leak.
    infer({16'hC000, 16'hC000, 16'hC000, 16'hC000}, 4, 3);
    expect_result(2'd0, 16'hC000, 1'b0);
    take();
    infer({16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, 4, 3);
    expect_result(2'd0, 16'h3C00, 1'b0);
    take();

    // Reset in ACCUM after two beats, then a clean inference.
    s_valid = 1'b1; s_score = 16'h4800; s_last = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 20 && !s_ready; w++) begin
        @(posedge clk); #1;
      end
      check("mid_s_ready", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    infer({16'h3800, 16'hC000, 16'h4000, 16'h3C00}, 4, 3);
    expect_result(2'd1, 16'h4000, 1'b0);
    take();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
